ball_dynamics: RTL

Per-frame ball physics integrator for the balance board. It consumes the two signed tilt values from the tilt accumulator (`sin_x`, `sin_y`) and integrates them into ball velocity and position on every frame tick. It clamps the ball inside the playfield, bounces it off walls with damping, and reports the updated on-screen position to the renderer.

---
 rtl/ball_dynamics.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ball_dynamics.sv
// ball_dynamics: per-frame ball physics integrator (tilt -> velocity -> position, wall bounce)
// Ports: clk, rst (async, active-low), frame_tick (update request), sin_x/sin_y (signed tilt),
//        ball_x/ball_y (pixel position), vel_x/vel_y (Q5.6 velocity), busy, upd_valid,
//        wall_hit {bottom,top,right,left}, overrun (tick dropped while busy).
// Optional: define BALL_FRICTION_EN to apply v -= v>>>4 before acceleration.
module ball_dynamics #(
  parameter int W_FIELD   = 640,
  parameter int H_FIELD   = 480,
  parameter int BALL_R    = 8,
  parameter int ACC_SHIFT = 4,
  parameter int VMAX      = 511
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic signed [10:0] sin_x,
  input  logic signed [10:0] sin_y,
  output logic        [9:0]  ball_x,
  output logic        [9:0]  ball_y,
  output logic signed [11:0] vel_x,
  output logic signed [11:0] vel_y,
  output logic               busy,
  output logic               upd_valid,
  output logic        [3:0]  wall_hit,
  output logic               overrun
);
  localparam logic [2:0] IDLE = 3'd0, ACCEL = 3'd1, MOVE = 3'd2, WALL = 3'd3, DONE = 3'd4;
  localparam logic signed [12:0] VHI = 13'(VMAX);
  localparam logic signed [12:0] VLO = -VHI;
  localparam logic signed [17:0] LO    = 18'(BALL_R << 6);
  localparam logic signed [17:0] HI_X  = 18'((W_FIELD - 1 - BALL_R) << 6);
  localparam logic signed [17:0] HI_Y  = 18'((H_FIELD - 1 - BALL_R) << 6);
  localparam logic [15:0] PX0 = 16'((W_FIELD / 2) << 6);
  localparam logic [15:0] PY0 = 16'((H_FIELD / 2) << 6);
  localparam logic [9:0]  BX0 = 10'(W_FIELD / 2);
  localparam logic [9:0]  BY0 = 10'(H_FIELD / 2);

  logic        [2:0]  state_q, state_d;
  logic signed [10:0] tx_q, ty_q;
  logic        [15:0] px_q, py_q;
  logic signed [11:0] vx_q, vy_q;
  logic signed [17:0] nx_q, ny_q;
  logic        [3:0]  hit_q, wh_q;
  logic        [9:0]  bx_q, by_q;
  logic signed [11:0] ox_q, oy_q;
  logic               upd_q, ovr_q;

  function automatic logic signed [11:0] accel(input logic signed [11:0] v, input logic signed [10:0] s);
    logic signed [11:0] f;
    logic signed [10:0] sg;
    logic signed [12:0] a;
`ifdef BALL_FRICTION_EN
    f = v - (v >>> 4);
`else
    f = v;
`endif
    sg = s >>> ACC_SHIFT;
    a = {f[11], f} + {{2{sg[10]}}, sg};
    return a > VHI ? VHI[11:0] : a < VLO ? VLO[11:0] : a[11:0];
  endfunction

  // 18-bit signed sum so an overshoot past either wall stays distinguishable
  function automatic logic signed [17:0] move(input logic [15:0] p, input logic signed [11:0] v);
    return {2'b00, p} + {{6{v[11]}}, v};
  endfunction

  // returns {hit_hi, hit_lo, position, velocity}
  function automatic logic [29:0] wall(input logic signed [17:0] n, input logic signed [11:0] v,
                                       input logic signed [17:0] hi);
    logic signed [11:0] b;
    b = -(v >>> 1);
    return n < LO ? {2'b01, LO[15:0], b} : n > hi ? {2'b10, hi[15:0], b} : {2'b00, n[15:0], v};
  endfunction

  always_comb
    state_d = state_q == IDLE ? (frame_tick ? ACCEL : IDLE) : state_q == DONE ? IDLE : state_q + 3'd1;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      ty_q    <= '0;
      px_q    <= PX0;
      py_q    <= PY0;
      vx_q    <= '0;
      vy_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      hit_q   <= '0;
      wh_q    <= '0;
      bx_q    <= BX0;
      by_q    <= BY0;
      ox_q    <= '0;
      oy_q    <= '0;
      upd_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovr_q   <= frame_tick && state_q != IDLE;
      upd_q   <= state_q == DONE;
      wh_q    <= state_q == DONE ? hit_q : 4'b0;
      if (state_q == IDLE && frame_tick) begin
        tx_q <= sin_x;
        ty_q <= sin_y;
      end
      if (state_q == ACCEL) begin
        vx_q <= accel(vx_q, tx_q);
        vy_q <= accel(vy_q, ty_q);
      end
      if (state_q == MOVE) begin
        nx_q <= move(px_q, vx_q);
        ny_q <= move(py_q, vy_q);
      end
      if (state_q == WALL) begin
        {hit_q[1:0], px_q, vx_q} <= wall(nx_q, vx_q, HI_X);
        {hit_q[3:2], py_q, vy_q} <= wall(ny_q, vy_q, HI_Y);
      end
      if (state_q == DONE) begin
        bx_q <= px_q[15:6];
        by_q <= py_q[15:6];
        ox_q <= vx_q;
        oy_q <= vy_q;
      end
    end

  assign ball_x    = bx_q;
  assign ball_y    = by_q;
  assign vel_x     = ox_q;
  assign vel_y     = oy_q;
  assign busy      = state_q != IDLE;
  assign upd_valid = upd_q;
  assign wall_hit  = wh_q;
  assign overrun   = ovr_q;
endmodule
